eprom_write_arbiter: RTL

//  Shares one serial EPROM byte writer between NREQ requesters.
//  - Round-robin arbitration.
//  - Presents the winner's address/data byte pair to the writer and pulses the start strobe.
//  - Waits for the writer's completion ack, then returns a per-requester done pulse.
//  - A watchdog aborts a transaction whose ack never arrives and flags err.

---
 rtl/eprom_write_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/eprom_write_arbiter.sv
// Round-robin arbiter sharing one serial EPROM byte writer among NREQ requesters.
// Launches a single-cycle start strobe, waits for the writer's ack or a watchdog timeout, then pulses done.
module eprom_write_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic              busy,
   output logic              wr_ctrl,
   output logic [7:0]        wr_address,
   output logic [7:0]        wr_data,
   input  logic              wr_ack
);

   localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TW     = $clog2(TIMEOUT);
   localparam int          NREQ_I = int'(NREQ);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   winner;
   logic [TW-1:0]   timer;

   logic [PW-1:0]   pick_c;
   logic            found_c;
   int              pos;

   // Search from the highest offset down so the first requester at or after ptr wins.
   always_comb begin
      pick_c  = '0;
      found_c = 1'b0;
      pos     = 0;
      for (int k = 0; k < NREQ_I; k++) begin
         pos = (int'(ptr) + NREQ_I - 1 - k) % NREQ_I;
         if (req[PW'(pos)]) begin
            pick_c  = PW'(pos);
            found_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ptr        <= '0;
         winner     <= '0;
         timer      <= '0;
         gnt        <= '0;
         done       <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         wr_ctrl    <= 1'b0;
         wr_address <= '0;
         wr_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found_c) begin
                  winner     <= pick_c;
                  wr_address <= req_addr[{pick_c, 3'b000} +: 8];
                  wr_data    <= req_data[{pick_c, 3'b000} +: 8];
                  gnt        <= NREQ'(1) << pick_c;
                  wr_ctrl    <= 1'b1;
                  busy       <= 1'b1;
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               wr_ctrl <= 1'b0;
               timer   <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               // A late ack in the final watchdog cycle still counts as success.
               if (wr_ack) begin
                  done  <= NREQ'(1) << winner;
                  err   <= 1'b0;
                  state <= DONE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  done  <= NREQ'(1) << winner;
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            DONE: begin
               gnt   <= '0;
               done  <= '0;
               err   <= 1'b0;
               busy  <= 1'b0;
               ptr   <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
